// File: rtl/fast_pat_load_pkg.sv
// Shared definitions for the pattern loader: FSM states and memory geometry.
package fast_pat_load_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PACK,
      WRITE,
      DRAIN,
      DONE
   } load_state_e;

   localparam int BEATS_PER_WORD = 8;
   localparam int MEM_DEPTH      = 1024;
   localparam int MEM_AW         = $clog2(MEM_DEPTH);

endpackage

// File: rtl/fast_pat_load_if.sv
// Stream input and on-chip memory write bus of the pattern loader.
interface fast_pat_load_if #(
   parameter int IN_W   = 32,
   parameter int MEM_W  = 256,
   parameter int ADDR_W = 11
);

   logic                 s_valid;
   logic                 s_ready;
   logic [IN_W-1:0]      s_data;
   logic                 s_eop;

   logic                 onchip_mem_chip_select;
   logic                 onchip_mem_write;
   logic [ADDR_W-1:0]    onchip_mem_addr;
   logic [MEM_W/8-1:0]   onchip_mem_byte_enable;
   logic [MEM_W-1:0]     onchip_mem_write_data;

   // The loader is the master of the memory bus and the sink of the stream.
   modport master (
      input  s_valid,
      input  s_data,
      input  s_eop,
      output s_ready,
      output onchip_mem_chip_select,
      output onchip_mem_write,
      output onchip_mem_addr,
      output onchip_mem_byte_enable,
      output onchip_mem_write_data
   );

   modport slave (
      output s_valid,
      output s_data,
      output s_eop,
      input  s_ready,
      input  onchip_mem_chip_select,
      input  onchip_mem_write,
      input  onchip_mem_addr,
      input  onchip_mem_byte_enable,
      input  onchip_mem_write_data
   );

endinterface

// File: rtl/fast_pat_load_pack.sv
// Beat packer: assembles IN_W-bit beats into one memory word and derives byte enables.
module fast_pat_pack
   import fast_pat_load_pkg::*;
#(
   parameter int IN_W  = 32,
   parameter int MEM_W = 256
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                beat_en,
   input  logic [IN_W-1:0]     beat_data,
   output logic [MEM_W-1:0]    word_next,
   output logic [MEM_W/8-1:0]  be_next,
   output logic                last_beat
);

   localparam int CNT_W      = $clog2(BEATS_PER_WORD);
   localparam int BEAT_BYTES = IN_W / 8;

   logic [MEM_W-1:0] word_q;
   logic [CNT_W-1:0] cnt_q;

   // word_next already contains the beat on the input so the word can be written the cycle after it is accepted.
   always_comb begin
      word_next = word_q;
      word_next[int'(cnt_q) * IN_W +: IN_W] = beat_data;
      be_next = '0;
      for (int b = 0; b < BEATS_PER_WORD; b++) begin
         if (CNT_W'(b) <= cnt_q) begin
            be_next[b * BEAT_BYTES +: BEAT_BYTES] = '1;
         end
      end
   end

   assign last_beat = (cnt_q == CNT_W'(BEATS_PER_WORD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (clear) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (beat_en) begin
         word_q <= word_next;
         cnt_q  <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/fast_pat_load.sv
// Pattern loader: packs a beat stream into memory words and writes them to on-chip
// pattern memory from a base address that wraps at the memory depth.
module fast_pat_load
   import fast_pat_load_pkg::*;
#(
   parameter int IN_W   = 32,
   parameter int MEM_W  = 256,
   parameter int ADDR_W = 11
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_start,
   input  logic [ADDR_W-1:0]   load_base_addr,
   input  logic [ADDR_W-1:0]   load_len,
   output logic                load_busy,
   output logic                load_done,
   output logic                load_err,
   input  logic                frame_busy,
   fast_pat_load_if.master     bus
);

   localparam int                BE_W      = MEM_W / 8;
   localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MEM_DEPTH - 1);

   load_state_e        state_q;
   logic [ADDR_W-1:0]  base_q;
   logic [ADDR_W-1:0]  len_q;
   logic [ADDR_W-1:0]  word_idx_q;
   logic               eop_seen_q;
   logic               partial_q;
   logic               busy_q;
   logic               done_q;
   logic               err_q;
   logic               s_ready_q;
   logic               mem_cs_q;
   logic               mem_write_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic [BE_W-1:0]    mem_be_q;
   logic [MEM_W-1:0]   mem_data_q;

   logic               beat_acc;
   logic               start_ok;
   logic               pack_beat;
   logic               pack_last;
   logic               word_end;
   logic               word_last;
   logic               pack_clear;
   logic [MEM_W-1:0]   pack_word;
   logic [BE_W-1:0]    pack_be;
   logic [ADDR_W-1:0]  wr_addr;

   assign beat_acc   = bus.s_valid & s_ready_q;
   assign start_ok   = (state_q == IDLE) & ~busy_q & load_start & ~frame_busy;
   assign pack_beat  = (state_q == PACK) & beat_acc;
   assign word_end   = pack_beat & (pack_last | bus.s_eop);
   assign pack_clear = start_ok | word_end;
   assign word_last  = (word_idx_q + ADDR_W'(1)) == len_q;
   assign wr_addr    = (base_q + word_idx_q) & ADDR_MASK;

   fast_pat_pack #(
      .IN_W  (IN_W),
      .MEM_W (MEM_W)
   ) u_pack (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (pack_clear),
      .beat_en   (pack_beat),
      .beat_data (bus.s_data),
      .word_next (pack_word),
      .be_next   (pack_be),
      .last_beat (pack_last)
   );

   // A zero-length load stays in IDLE with busy set for one cycle, then reports DONE without writing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         base_q      <= '0;
         len_q       <= '0;
         word_idx_q  <= '0;
         eop_seen_q  <= 1'b0;
         partial_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         s_ready_q   <= 1'b0;
         mem_cs_q    <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_data_q  <= '0;
      end else begin
         done_q      <= 1'b0;
         mem_cs_q    <= 1'b0;
         mem_write_q <= 1'b0;
         mem_be_q    <= '0;
         unique case (state_q)
            IDLE: begin
               if (busy_q) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else if (start_ok) begin
                  base_q     <= load_base_addr;
                  len_q      <= load_len;
                  word_idx_q <= '0;
                  eop_seen_q <= 1'b0;
                  partial_q  <= 1'b0;
                  err_q      <= 1'b0;
                  busy_q     <= 1'b1;
                  if (load_len != '0) begin
                     state_q   <= PACK;
                     s_ready_q <= 1'b1;
                  end
               end
            end
            PACK: begin
               if (word_end) begin
                  state_q     <= WRITE;
                  s_ready_q   <= 1'b0;
                  mem_cs_q    <= 1'b1;
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= wr_addr;
                  mem_be_q    <= pack_be;
                  mem_data_q  <= pack_word;
                  eop_seen_q  <= bus.s_eop;
                  partial_q   <= ~pack_last;
               end
            end
            WRITE: begin
               word_idx_q <= word_idx_q + ADDR_W'(1);
               if (eop_seen_q) begin
                  if (!word_last || partial_q) begin
                     err_q <= 1'b1;
                  end
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else if (word_last) begin
                  err_q     <= 1'b1;
                  state_q   <= DRAIN;
                  s_ready_q <= 1'b1;
               end else begin
                  state_q   <= PACK;
                  s_ready_q <= 1'b1;
               end
            end
            DRAIN: begin
               if (beat_acc && bus.s_eop) begin
                  state_q   <= DONE;
                  s_ready_q <= 1'b0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign load_busy = busy_q;
   assign load_done = done_q;
   assign load_err  = err_q;

   assign bus.s_ready                = s_ready_q;
   assign bus.onchip_mem_chip_select = mem_cs_q;
   assign bus.onchip_mem_write       = mem_write_q;
   assign bus.onchip_mem_addr        = mem_addr_q;
   assign bus.onchip_mem_byte_enable = mem_be_q;
   assign bus.onchip_mem_write_data  = mem_data_q;

endmodule

// File: tb/tb_fast_pat_load.sv
// Self-checking bench for fast_pat_load: a beat-level model queues expected memory
// writes which a negedge monitor pops and compares against the memory bus.
module tb_fast_pat_load;

   localparam int IN_W   = 32;
   localparam int MEM_W  = 256;
   localparam int ADDR_W = 11;
   localparam int BE_W   = MEM_W / 8;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [MEM_W-1:0]  data;
      logic [BE_W-1:0]   be;
      int                cyc;
   } wr_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               load_start = 1'b0;
   logic [ADDR_W-1:0]  load_base_addr = '0;
   logic [ADDR_W-1:0]  load_len = '0;
   logic               load_busy;
   logic               load_done;
   logic               load_err;
   logic               frame_busy = 1'b0;

   int n_compared   = 0;
   int n_mismatched = 0;
   int cyc          = 0;
   int done_cnt     = 0;

   wr_t exp_q[$];

   int               m_base;
   int               m_len;
   int               m_k;
   int               m_widx;
   int               m_done_cyc;
   logic [MEM_W-1:0] m_word;
   logic [BE_W-1:0]  m_be;
   logic             m_drop;
   logic             m_err;

   fast_pat_load_if #(.IN_W(IN_W), .MEM_W(MEM_W), .ADDR_W(ADDR_W)) bus ();

   fast_pat_load #(.IN_W(IN_W), .MEM_W(MEM_W), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .load_start     (load_start),
      .load_base_addr (load_base_addr),
      .load_len       (load_len),
      .load_busy      (load_busy),
      .load_done      (load_done),
      .load_err       (load_err),
      .frame_busy     (frame_busy),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor: every strobe must match the oldest expected write, including the cycle it lands in.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.onchip_mem_write === 1'b1) begin
            n_compared++;
            if (exp_q.size() == 0) begin
               n_mismatched++;
               $display("[TB] FAIL unexpected_write: addr=%h be=%h, required no write", bus.onchip_mem_addr, bus.onchip_mem_byte_enable);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               if (bus.onchip_mem_addr !== e.addr || bus.onchip_mem_write_data !== e.data ||
                   bus.onchip_mem_byte_enable !== e.be || bus.onchip_mem_chip_select !== 1'b1 || cyc !== e.cyc) begin
                  n_mismatched++;
                  $display("[TB] FAIL mem_write: got addr=%h be=%h cs=%b cyc=%0d data=%h, required addr=%h be=%h cs=1 cyc=%0d data=%h",
                           bus.onchip_mem_addr, bus.onchip_mem_byte_enable, bus.onchip_mem_chip_select, cyc, bus.onchip_mem_write_data,
                           e.addr, e.be, e.cyc, e.data);
               end
            end
         end else begin
            n_compared++;
            if (bus.onchip_mem_chip_select !== 1'b0 || bus.onchip_mem_byte_enable !== '0) begin
               n_mismatched++;
               $display("[TB] FAIL idle_bus: cs=%b be=%h, required cs=0 be=0", bus.onchip_mem_chip_select, bus.onchip_mem_byte_enable);
            end
         end
         if (load_done === 1'b1) done_cnt++;
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, required finish within 400000 time units");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic start_load(input int base, input int len);
      @(negedge clk);
      load_start     = 1'b1;
      load_base_addr = ADDR_W'(base);
      load_len       = ADDR_W'(len);
      @(posedge clk);
      #1;
      load_start = 1'b0;
      m_base     = base;
      m_len      = len;
      m_k        = 0;
      m_widx     = 0;
      m_word     = '0;
      m_be       = '0;
      m_drop     = 1'b0;
      m_err      = 1'b0;
      m_done_cyc = -1;
      n_compared++;
      if (load_busy !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL busy_after_start: load_busy=%b, required 1", load_busy);
      end
   endtask

   task automatic send_beat(input logic [IN_W-1:0] data, input logic eop, input int gap);
      int  guard;
      wr_t e;
      logic partial;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = data;
      bus.s_eop   = eop;
      guard = 0;
      while (bus.s_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      n_compared++;
      if (bus.s_ready !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL beat_handshake: s_ready=%b after %0d cycles, required 1", bus.s_ready, guard);
         bus.s_valid = 1'b0;
         bus.s_eop   = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      bus.s_eop   = 1'b0;
      if (!m_drop) begin
         m_word[m_k * IN_W +: IN_W] = data;
         m_be[m_k * (IN_W / 8) +: (IN_W / 8)] = '1;
         m_k++;
         if (m_k == 8 || eop) begin
            partial = (m_k != 8);
            e.addr = ADDR_W'((m_base + m_widx) % 1024);
            e.data = m_word;
            e.be   = m_be;
            e.cyc  = cyc;
            exp_q.push_back(e);
            m_widx++;
            m_k    = 0;
            m_word = '0;
            m_be   = '0;
            if (eop) begin
               m_err      = (m_widx != m_len) || partial;
               m_done_cyc = cyc + 1;
            end else if (m_widx == m_len) begin
               m_drop = 1'b1;
               m_err  = 1'b1;
            end
         end
      end else if (eop) begin
         m_done_cyc = cyc;
      end
   endtask

   task automatic wait_done();
      int guard;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (load_done !== 1'b1 && guard < 60);
      n_compared++;
      if (load_done !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL done_timeout: load_done=%b after %0d cycles, required 1", load_done, guard);
         return;
      end
      n_compared++;
      if (cyc !== m_done_cyc) begin
         n_mismatched++;
         $display("[TB] FAIL done_cycle: load_done in cycle %0d, required cycle %0d", cyc, m_done_cyc);
      end
      n_compared++;
      if (load_err !== m_err) begin
         n_mismatched++;
         $display("[TB] FAIL load_err: got %b, required %b", load_err, m_err);
      end
      n_compared++;
      if (load_busy !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL busy_at_done: load_busy=%b, required 0", load_busy);
      end
      n_compared++;
      if (exp_q.size() != 0) begin
         n_mismatched++;
         $display("[TB] FAIL missing_writes: %0d expected writes not seen, required 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
      n_compared++;
      if (load_done !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL done_pulse: load_done=%b one cycle later, required 0", load_done);
      end
   endtask

   task automatic run_load(input int base, input int len, input int nbeats, input int eop_at, input bit gaps, input bit count_data);
      start_load(base, len);
      for (int i = 0; i < nbeats; i++) begin
         send_beat(count_data ? IN_W'(i) : IN_W'($urandom), (i == eop_at), gaps ? int'($urandom_range(0, 2)) : 0);
      end
      wait_done();
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_compared++;
      if (load_busy !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0 || bus.s_ready !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_ctrl: busy=%b done=%b err=%b s_ready=%b, required all 0", load_busy, load_done, load_err, bus.s_ready);
      end
      n_compared++;
      if (bus.onchip_mem_write !== 1'b0 || bus.onchip_mem_chip_select !== 1'b0 || bus.onchip_mem_addr !== '0 ||
          bus.onchip_mem_byte_enable !== '0 || bus.onchip_mem_write_data !== '0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_mem: wr=%b cs=%b addr=%h be=%h, required all 0", bus.onchip_mem_write,
                  bus.onchip_mem_chip_select, bus.onchip_mem_addr, bus.onchip_mem_byte_enable);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_compared++;
      if (load_busy !== 1'b0 || bus.s_ready !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL idle_after_reset: busy=%b s_ready=%b, required 0 0", load_busy, bus.s_ready);
      end
   endtask

   task automatic test_full_load();
      run_load(0, 2, 16, 15, 1'b0, 1'b1);
   endtask

   task automatic test_wrap();
      run_load(1023, 2, 16, 15, 1'b1, 1'b0);
   endtask

   task automatic test_short_eop();
      run_load(100, 2, 11, 10, 1'b0, 1'b0);
   endtask

   task automatic test_drain();
      run_load(200, 1, 12, 11, 1'b0, 1'b0);
   endtask

   task automatic test_frame_busy_zero_len();
      int c0;
      @(negedge clk);
      frame_busy     = 1'b1;
      load_start     = 1'b1;
      load_base_addr = ADDR_W'(3);
      load_len       = ADDR_W'(2);
      @(posedge clk);
      #1;
      load_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_compared++;
         if (load_busy !== 1'b0 || bus.s_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL start_while_frame_busy: busy=%b s_ready=%b, required 0 0", load_busy, bus.s_ready);
         end
      end
      frame_busy = 1'b0;
      @(negedge clk);
      c0             = cyc;
      load_start     = 1'b1;
      load_base_addr = ADDR_W'(7);
      load_len       = '0;
      @(posedge clk);
      #1;
      load_start = 1'b0;
      @(negedge clk);
      n_compared++;
      if (load_done !== 1'b0 || load_busy !== 1'b1 || cyc !== c0 + 1) begin
         n_mismatched++;
         $display("[TB] FAIL zero_len_first: done=%b busy=%b, required done=0 busy=1", load_done, load_busy);
      end
      @(negedge clk);
      n_compared++;
      if (load_done !== 1'b1 || load_busy !== 1'b0 || load_err !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL zero_len_done: done=%b busy=%b err=%b, required 1 0 0", load_done, load_busy, load_err);
      end
      @(negedge clk);
      n_compared++;
      if (load_done !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL zero_len_pulse: load_done=%b, required 0", load_done);
      end
   endtask

   task automatic test_reset_mid_load();
      int dc;
      start_load(300, 2);
      for (int i = 0; i < 5; i++) send_beat(IN_W'($urandom), 1'b0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      n_compared++;
      if (load_busy !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0 || bus.s_ready !== 1'b0 ||
          bus.onchip_mem_write !== 1'b0 || bus.onchip_mem_chip_select !== 1'b0 || bus.onchip_mem_addr !== '0 ||
          bus.onchip_mem_byte_enable !== '0 || bus.onchip_mem_write_data !== '0) begin
         n_mismatched++;
         $display("[TB] FAIL async_reset: busy=%b done=%b s_ready=%b wr=%b addr=%h be=%h, required all 0",
                  load_busy, load_done, bus.s_ready, bus.onchip_mem_write, bus.onchip_mem_addr, bus.onchip_mem_byte_enable);
      end
      n_compared++;
      if (exp_q.size() != 0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_pending: %0d writes queued, required 0", exp_q.size());
         exp_q.delete();
      end
      dc = done_cnt;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      n_compared++;
      if (done_cnt !== dc || load_busy !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_no_done: done pulses=%0d busy=%b, required %0d and 0", done_cnt, load_busy, dc);
      end
      run_load(300, 1, 8, 7, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      fork
         run_load(500, 3, 24, 23, 1'b1, 1'b0);
         begin
            repeat (6) @(negedge clk);
            load_start     = 1'b1;
            load_base_addr = ADDR_W'(9);
            load_len       = ADDR_W'(1);
            @(posedge clk);
            #1;
            load_start = 1'b0;
            frame_busy = 1'b1;
         end
      join
      frame_busy = 1'b0;
      run_load(40, 3, 10, 9, 1'b0, 1'b0);
      run_load(41, 1, 8, 7, 1'b0, 1'b0);
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_eop   = 1'b0;
      test_reset();
      test_full_load();
      test_wrap();
      test_short_eop();
      test_drain();
      test_frame_busy_zero_len();
      test_reset_mid_load();
      test_back_to_back();
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
